// File: rtl/wb_grf_if.sv
// Write-back / register-file port bundle: WB-stage write inputs, ID-stage read ports,
// and the commit status outputs.
interface wb_grf_if;
  logic [31:0] wbDmData;
  logic [31:0] wbALUOut;
  logic [4:0]  wbWriteAddr;
  logic [31:0] wbPC;
  logic [1:0]  wbMemToReg;
  logic [31:0] wbInstr;
  logic [4:0]  rsAddr;
  logic [4:0]  rtAddr;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [15:0] wrCount;

  modport master (
    output wbDmData, wbALUOut, wbWriteAddr, wbPC, wbMemToReg, wbInstr, rsAddr, rtAddr,
    input  rsData, rtData, wrEn, wrAddr, wrData, wrCount
  );

  modport slave (
    input  wbDmData, wbALUOut, wbWriteAddr, wbPC, wbMemToReg, wbInstr, rsAddr, rtAddr,
    output rsData, rtData, wrEn, wrAddr, wrData, wrCount
  );
endinterface

// File: rtl/wb_grf.sv
// General register file with write-back mux, same-cycle read bypass and a count of
// committed writes. Register 0 is hardwired to zero.
module wb_grf (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);
  logic [31:0] regs_q [32];
  logic [15:0] wrCount_q, wrCount_d;
  logic [31:0] wr_data;
  logic        wr_en;

  always_comb begin
    wr_data = '0;
    unique case (bus.wbMemToReg)
      2'b00:   wr_data = bus.wbALUOut;
      2'b01:   wr_data = bus.wbDmData;
      2'b10:   wr_data = bus.wbPC + 32'd8;
      default: wr_data = '0;
    endcase
  end

  assign wr_en = (bus.wbWriteAddr != 5'd0) && (bus.wbInstr != 32'd0) &&
                 (bus.wbMemToReg != 2'b11);

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    if (addr == 5'd0)
      return '0;
    else if (wr_en && addr == bus.wbWriteAddr)
      return wr_data;
    else
      return regs_q[addr];
  endfunction

  assign bus.rsData  = read_port(bus.rsAddr);
  assign bus.rtData  = read_port(bus.rtAddr);
  assign bus.wrEn    = wr_en;
  assign bus.wrAddr  = bus.wbWriteAddr;
  assign bus.wrData  = wr_data;
  assign bus.wrCount = wrCount_q;

  assign wrCount_d = wr_en ? wrCount_q + 16'd1 : wrCount_q;

  // wr_en already excludes address 0, so regs_q[0] only ever holds its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      wrCount_q <= '0;
    end else begin
      if (wr_en) regs_q[bus.wbWriteAddr] <= wr_data;
      wrCount_q <= wrCount_d;
    end
  end
endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: spec vector table, corner-case sequences and
// random traffic against an array-based register file model.
module tb_wb_grf;
  logic clk = 1'b0;
  logic reset = 1'b1;
  wb_grf_if bus ();

  wb_grf dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] mregs [32];
  int unsigned mcount = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu, dm, pc, instr;
    logic [4:0]  wa, rs, rt;
    logic [31:0] exp_wd;
    logic        exp_en;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [31:0] m_wd();
    case (bus.wbMemToReg)
      2'b00:   return bus.wbALUOut;
      2'b01:   return bus.wbDmData;
      2'b10:   return bus.wbPC + 32'd8;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_en();
    return bus.wbWriteAddr != 0 && bus.wbInstr != 0 && bus.wbMemToReg != 2'b11;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (m_en() && a == bus.wbWriteAddr) return m_wd();
    return mregs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcount = 0;
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] dm,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] wa, input logic [4:0] rs, input logic [4:0] rt);
    bus.wbMemToReg  = sel;
    bus.wbALUOut    = alu;
    bus.wbDmData    = dm;
    bus.wbPC        = pc;
    bus.wbInstr     = instr;
    bus.wbWriteAddr = wa;
    bus.rsAddr      = rs;
    bus.rtAddr      = rt;
  endtask

  task automatic check_comb(input string tag);
    check32({tag, ".wrData"}, bus.wrData, m_wd());
    check32({tag, ".wrEn"},   {31'd0, bus.wrEn}, {31'd0, m_en()});
    check32({tag, ".wrAddr"}, {27'd0, bus.wrAddr}, {27'd0, bus.wbWriteAddr});
    check32({tag, ".rsData"}, bus.rsData, m_rd(bus.rsAddr));
    check32({tag, ".rtData"}, bus.rtData, m_rd(bus.rtAddr));
  endtask

  // Advance one rising edge, apply the spec's commit rule to the model, optionally check count.
  task automatic edge_update(input bit chk);
    @(posedge clk);
    if (!reset && m_en()) begin
      mregs[bus.wbWriteAddr] = m_wd();
      mcount = (mcount + 1) % 65536;
    end
    #1;
    if (chk) check32("wrCount", {16'd0, bus.wrCount}, mcount);
  endtask

  initial begin
    tbl[0] = '{2'b00, 32'h12345678, 32'h0, 32'h0, 32'h01095020, 5'd8, 5'd8, 5'd0, 32'h12345678, 1'b1};
    tbl[1] = '{2'b10, 32'h0, 32'h0, 32'h00003000, 32'h0C000000, 5'd31, 5'd31, 5'd8, 32'h00003008, 1'b1};
    tbl[2] = '{2'b10, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0C000000, 5'd30, 5'd31, 5'd30, 32'h00000004, 1'b1};
    tbl[3] = '{2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 32'h01095020, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 1'b0};
    tbl[4] = '{2'b00, 32'h55555555, 32'h0, 32'h0, 32'h00000000, 5'd5, 5'd5, 5'd8, 32'h55555555, 1'b0};
    tbl[5] = '{2'b01, 32'h0, 32'hAAAA5555, 32'h0, 32'h8C000000, 5'd9, 5'd9, 5'd9, 32'hAAAA5555, 1'b1};
    tbl[6] = '{2'b11, 32'h77777777, 32'h66666666, 32'h0, 32'h8C000000, 5'd9, 5'd9, 5'd31, 32'h00000000, 1'b0};

    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check32("reset.wrCount", {16'd0, bus.wrCount}, 32'd0);
    check32("reset.rs0", bus.rsData, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Spec vector table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(tbl[i].sel, tbl[i].alu, tbl[i].dm, tbl[i].pc, tbl[i].instr, tbl[i].wa, tbl[i].rs, tbl[i].rt);
      #1;
      check32($sformatf("tbl%0d.wrData", i), bus.wrData, tbl[i].exp_wd);
      check32($sformatf("tbl%0d.wrEn", i), {31'd0, bus.wrEn}, {31'd0, tbl[i].exp_en});
      check_comb($sformatf("tbl%0d", i));
      edge_update(1'b1);
      bus.wbInstr = 32'd0;
      bus.rsAddr  = tbl[i].wa;
      #1;
      check32($sformatf("tbl%0d.readback", i), bus.rsData, m_rd(tbl[i].wa));
    end
    check32("tbl.reg8", mregs[8], 32'h12345678);

    // Bypass on both ports, and reserved select suppressing it
    @(negedge clk);
    drive(2'b00, 32'h1, 32'h0, 32'h0, 32'h1, 5'd9, 5'd9, 5'd9);
    edge_update(1'b1);
    @(negedge clk);
    drive(2'b01, 32'h0, 32'hAAAA5555, 32'h0, 32'h1, 5'd9, 5'd9, 5'd9);
    #1;
    check32("byp.rs", bus.rsData, 32'hAAAA5555);
    check32("byp.rt", bus.rtData, 32'hAAAA5555);
    bus.wbMemToReg = 2'b11;
    #1;
    check32("rsv.rs", bus.rsData, 32'h1);
    check32("rsv.rt", bus.rtData, 32'h1);
    edge_update(1'b1);
    bus.wbInstr = 32'd0;
    #1;
    check32("rsv.reg9", bus.rsData, 32'h1);

    // Same address on consecutive edges: later value wins
    @(negedge clk);
    drive(2'b00, 32'hA0A0A0A0, 32'h0, 32'h0, 32'h1, 5'd3, 5'd3, 5'd0);
    edge_update(1'b1);
    @(negedge clk);
    bus.wbALUOut = 32'hB1B1B1B1;
    #1;
    check32("b2b.bypass", bus.rsData, 32'hB1B1B1B1);
    edge_update(1'b1);
    bus.wbInstr = 32'd0;
    #1;
    check32("b2b.reg3", bus.rsData, 32'hB1B1B1B1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom | 32'd1,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) bus.rsAddr = bus.wbWriteAddr;
      #1;
      check_comb("rnd");
      edge_update(1'b1);
    end

    // Asynchronous reset mid-cycle, then held across a write edge
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check32("arst.wrCount", {16'd0, bus.wrCount}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      bus.rsAddr = 5'(a);
      bus.rtAddr = 5'(31 - a);
      #1;
      check32($sformatf("arst.rs%0d", a), bus.rsData, 32'd0);
    end
    @(negedge clk);
    drive(2'b00, 32'hCAFEF00D, 32'h0, 32'h0, 32'h1, 5'd7, 5'd7, 5'd0);
    #1;
    check32("arst.bypass", bus.rsData, 32'hCAFEF00D);
    edge_update(1'b1);
    bus.wbInstr = 32'd0;
    #1;
    check32("arst.noCommit", bus.rsData, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.wbInstr = 32'h1;
    edge_update(1'b1);
    bus.wbInstr = 32'd0;
    #1;
    check32("arst.firstWrite", bus.rsData, 32'hCAFEF00D);
    check32("arst.count1", {16'd0, bus.wrCount}, 32'd1);

    // Counter wrap: 65536 writes return to 0, one more gives 1
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    drive(2'b00, 32'h5, 32'h0, 32'h0, 32'h1, 5'd12, 5'd12, 5'd0);
    repeat (65535) edge_update(1'b0);
    check32("wrap.ffff", {16'd0, bus.wrCount}, 32'h0000FFFF);
    edge_update(1'b0);
    check32("wrap.0000", {16'd0, bus.wrCount}, 32'h00000000);
    edge_update(1'b0);
    check32("wrap.0001", {16'd0, bus.wrCount}, 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_grf.md
WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 wbDmData  input  32  load data registered by the MEM/WB pipeline register.
REQ-004 wbALUOut  input  32  ALU result registered by the MEM/WB pipeline register.
REQ-005 wbWriteAddr  input  5  destination register number.
REQ-006 wbPC  input  32  PC of the instruction in WB.
REQ-007 wbMemToReg  input  2  write-data select: 00 ALU, 01 DM, 10 PC+8 (link), 11 reserved.
REQ-008 wbInstr  input  32  instruction word in WB; 0x00000000 denotes bubble/nop.
REQ-009 rsAddr  input  5  read port A address (ID stage).
REQ-010 rtAddr  input  5  read port B address (ID stage).
REQ-011 rsData  output  32  read port A data.
REQ-012 rtData  output  32  read port B data.
REQ-013 wrEn  output  1  combinational: a register write commits at the next rising edge.
REQ-014 wrAddr  output  5  equals wbWriteAddr.
REQ-015 wrData  output  32  selected write-back value.
REQ-016 wrCount  output  16  registered count of committed writes.

Function
REQ-017 wrData SHALL be wbALUOut for 00, wbDmData for 01, wbPC+32'd8 (modulo 2^32) for 10, and 0 for 11.
REQ-018 wrEn SHALL be 1 only when wbWriteAddr!=0 AND wbInstr!=0 AND wbMemToReg!=11.
REQ-019 Register file: 32 x 32-bit; on a rising edge with wrEn=1, reg[wbWriteAddr] <= wrData; otherwise no register changes.
REQ-020 reg[0] SHALL read 0 always and SHALL never be written, whatever the inputs.
REQ-021 Reads are combinational; rsData = 0 if rsAddr==0, else wrData if wrEn && rsAddr==wbWriteAddr (same-cycle bypass), else reg[rsAddr].
REQ-022 rtData follows the rule of REQ-021 with rtAddr; both ports may bypass in the same cycle.
REQ-023 Write latency: a value written at edge N is visible from reg[] after edge N; via bypass it is visible during the cycle before edge N.
REQ-024 wrCount SHALL increment by 1 on every rising edge with wrEn=1, wrap 0xFFFF->0x0000, and hold otherwise.
REQ-025 A write of an identical value SHALL still count as a committed write.
REQ-026 Reserved select (11) SHALL be treated as a no-write: no register update, no count, no bypass.
REQ-027 Writes to the same address on consecutive edges: the later edge's value wins; bypass always reflects the current cycle's wrData.

Reset
REQ-028 reset=1 SHALL asynchronously clear all 32 registers and wrCount to 0, without waiting for a clock edge.
REQ-029 While reset=1, no write SHALL commit and wrCount SHALL hold at 0; rsData/rtData SHALL return 0 unless bypassed.
REQ-030 If reset is asserted coincident with a write edge, reset SHALL win and the register SHALL remain 0.
REQ-031 After reset deasserts, the first rising edge with wrEn=1 SHALL commit normally.

Verification
REQ-032 ALU write: MemToReg=00, addr=8, ALUOut=0x12345678, instr=0x01095020; edge; rsAddr=8 -> rsData=0x12345678, wrCount=1.
REQ-033 Link write: MemToReg=10, addr=31, PC=0x00003000 -> wrData=0x00003008; after edge, reg[31]=0x00003008; PC=0xFFFFFFFC -> wrData=0x00000004.
REQ-034 $0 protection and bubble: addr=0, ALUOut=0xDEADBEEF -> wrEn=0, rsAddr=0 reads 0; addr=5, instr=0 -> wrEn=0, reg[5] unchanged, count unchanged.
REQ-035 Bypass: reg[9]=0x1 committed; next cycle MemToReg=01, addr=9, DmData=0xAAAA5555, rsAddr=rtAddr=9 -> both read 0xAAAA5555 before the edge; MemToReg=11 same case -> both read 0x1.
REQ-036 Counter wrap: 65536 committed writes -> wrCount returns to 0x0000; 65537th -> 0x0001.
REQ-037 Async reset: mid-cycle reset pulse (not edge-aligned) -> all regs and wrCount read 0 immediately; reset held across an edge with wrEn=1 -> no commit.
